rst_req_ctrl: RTL and testbench

//   Reset request controller: the source side of the per-domain reset synchronizers.
//   - Collects reset requests (software, watchdog, debug, ...).
//   - Asserts a fixed-width reset pulse on every downstream domain.
//   - Releases the domains in ascending order, GAP_CYC cycles apart.
//   - Each rst_no output is meant to drive the async-assert / sync-release synchronizer of its domain.

---
 rtl/rst_req_ctrl.sv | 123 ++++++++++++
 tb/tb_rst_req_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset request controller: collects reset requests, holds every domain in reset for a fixed
// pulse, then releases domains in index order. Optional sticky cause register via RST_CAUSE_EN.
module rst_req_ctrl #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned NUM_DOM   = 2,
    parameter int unsigned PULSE_CYC = 16,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned CNT_W     =
        $clog2(((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC) + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] req_mask_i,
`ifdef RST_CAUSE_EN
    input  logic               cause_clr_i,
    output logic [NUM_REQ-1:0] cause_o,
`endif
    output logic [NUM_DOM-1:0] rst_no,
    output logic               busy_o
);

    localparam int unsigned DomW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] PulseLd = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GapLd   = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRel
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DomW-1:0]    dom_q;
    logic [NUM_DOM-1:0] rst_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] req_act;
    logic               trig;

    assign req_act = req_i & ~req_mask_i;
    assign trig    = |req_act;

    // A new request has priority in every state, including the final release edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || trig) begin
            state_q <= StHold;
            cnt_q   <= PulseLd;
            dom_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    rst_q  <= '1;
                    busy_q <= 1'b0;
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        dom_q <= '0;
                        cnt_q <= GapLd;
                        if (NUM_DOM == 1) begin
                            state_q <= StIdle;
                            rst_q   <= '1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StRel;
                            for (int k = 0; k < int'(NUM_DOM); k++) begin
                                rst_q[k] <= (k == 0);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StRel: begin
                    if (cnt_q == '0) begin
                        cnt_q <= GapLd;
                        if (int'(dom_q) + 2 >= int'(NUM_DOM)) begin
                            state_q <= StIdle;
                            rst_q   <= '1;
                            busy_q  <= 1'b0;
                        end else begin
                            dom_q <= dom_q + 1'b1;
                            // Thermometer code keeps release strictly in index order.
                            for (int k = 0; k < int'(NUM_DOM); k++) begin
                                rst_q[k] <= (k <= int'(dom_q) + 1);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StHold;
                    cnt_q   <= PulseLd;
                    dom_q   <= '0;
                    rst_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rst_no = rst_q;
    assign busy_o = busy_q;

`ifdef RST_CAUSE_EN
    logic [NUM_REQ-1:0] cause_q;

    // Set beats clear for the same bit; request-driven resets leave the cause intact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_q <= '0;
        end else begin
            cause_q <= (cause_clr_i ? '0 : cause_q) | req_act;
        end
    end

    assign cause_o = cause_q;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed self-checking bench for rst_req_ctrl (default parameters).
module tb_rst_req_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] req_i = '0;
    logic [2:0] req_mask_i = '0;
    logic [1:0] rst_no;
    logic       busy_o;
`ifdef RST_CAUSE_EN
    logic       cause_clr_i = 1'b0;
    logic [2:0] cause_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rst_req_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .req_mask_i (req_mask_i),
`ifdef RST_CAUSE_EN
        .cause_clr_i(cause_clr_i),
        .cause_o    (cause_o),
`endif
        .rst_no     (rst_no),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the edge that loaded the hold count; ends after rst_no[0] rises.
    task automatic hold_phase(input string tag);
        chk({tag, "_hold_start"}, {6'd0, rst_no}, 8'h00);
        chk({tag, "_busy_start"}, {7'd0, busy_o}, 8'h01);
        for (int i = 1; i < 16; i++) begin
            step();
            chk({tag, "_hold"}, {6'd0, rst_no}, 8'h00);
        end
        step();
        chk({tag, "_rel0"}, {6'd0, rst_no}, 8'h01);
        chk({tag, "_rel0_busy"}, {7'd0, busy_o}, 8'h01);
    endtask

    task automatic rel_phase(input string tag);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_gap"}, {6'd0, rst_no}, 8'h01);
        end
        step();
        chk({tag, "_rel1"}, {6'd0, rst_no}, 8'h03);
        chk({tag, "_idle_busy"}, {7'd0, busy_o}, 8'h00);
    endtask

    task automatic pulse_req(input logic [2:0] r);
        req_i = r;
        step();
        req_i = '0;
    endtask

    initial begin
        // 1. Power-on
        repeat (3) step();
        chk("por_rst", {6'd0, rst_no}, 8'h00);
`ifdef RST_CAUSE_EN
        chk("por_cause", {5'd0, cause_o}, 8'h00);
`endif
        rst_i = 1'b0;
        hold_phase("por");
        rel_phase("por");

        // 2. Single unmasked request
        step();
        pulse_req(3'b010);
`ifdef RST_CAUSE_EN
        chk("t2_cause", {5'd0, cause_o}, 8'h02);
`endif
        hold_phase("t2");
        rel_phase("t2");

        // 3. Masked request is ignored
        req_mask_i = 3'b001;
        pulse_req(3'b001);
        req_mask_i = '0;
        step();
        chk("t3_rst", {6'd0, rst_no}, 8'h03);
        chk("t3_busy", {7'd0, busy_o}, 8'h00);
`ifdef RST_CAUSE_EN
        chk("t3_cause", {5'd0, cause_o}, 8'h02);
`endif

        // 4. Request during release restarts the hold
        pulse_req(3'b100);
        hold_phase("t4a");
        pulse_req(3'b001);
`ifdef RST_CAUSE_EN
        chk("t4_cause", {5'd0, cause_o}, 8'h07);
`endif
        hold_phase("t4b");
        rel_phase("t4b");

        // 5. Request on the final release edge wins
        pulse_req(3'b010);
        hold_phase("t5a");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_gap", {6'd0, rst_no}, 8'h01);
        end
        pulse_req(3'b010);
        hold_phase("t5b");
        rel_phase("t5b");

        // 6. Cause clear vs. same-cycle set
`ifdef RST_CAUSE_EN
        cause_clr_i = 1'b1;
        step();
        cause_clr_i = 1'b0;
        chk("t6_clr0", {5'd0, cause_o}, 8'h00);
`endif
        pulse_req(3'b001);
`ifdef RST_CAUSE_EN
        chk("t6_set1", {5'd0, cause_o}, 8'h01);
`endif
        hold_phase("t6a");
        rel_phase("t6a");
`ifdef RST_CAUSE_EN
        cause_clr_i = 1'b1;
`endif
        pulse_req(3'b100);
`ifdef RST_CAUSE_EN
        cause_clr_i = 1'b0;
        chk("t6_setwins", {5'd0, cause_o}, 8'h04);
`endif
        hold_phase("t6b");
        rel_phase("t6b");
`ifdef RST_CAUSE_EN
        cause_clr_i = 1'b1;
        step();
        cause_clr_i = 1'b0;
        chk("t6_clr1", {5'd0, cause_o}, 8'h00);
`endif
        step();
        chk("final_idle", {6'd0, rst_no}, 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
